// File: rtl/muldiv_pkg.sv
// Shared constants and types for the multiply/divide issue path.
package muldiv_pkg;

  localparam int unsigned ROB_TAG_W_DEFAULT = 5;
  localparam int unsigned MUL_LATENCY       = 1;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_SHIFT,
    SLOT_LOAD,
    SLOT_CLEAR
  } slot_sel_e;

  // MUL-class ops all have funct3[2] clear; DIV/REM have it set.
  function automatic logic is_mul_funct3(input logic [31:0] inst);
    return inst[14] == 1'b0;
  endfunction

endpackage

// File: rtl/mul_rs_entry.sv
// One reservation slot: selects hold/shift-in/dispatch-load/clear and snoops the CDB
// on whichever source is being written.
module mul_rs_entry
  import muldiv_pkg::*;
#(
  parameter int unsigned ROB_TAG_W = ROB_TAG_W_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  slot_sel_e            sel,
  input  logic                 cdb_valid,
  input  logic [ROB_TAG_W-1:0] cdb_tag,
  input  logic [31:0]          cdb_value,
  input  logic                 sh_valid,
  input  logic [31:0]          sh_inst,
  input  logic [31:0]          sh_pc,
  input  logic [ROB_TAG_W-1:0] sh_tag,
  input  logic                 sh_rs1_rdy,
  input  logic [ROB_TAG_W-1:0] sh_rs1_tag,
  input  logic [31:0]          sh_rs1_val,
  input  logic                 sh_rs2_rdy,
  input  logic [ROB_TAG_W-1:0] sh_rs2_tag,
  input  logic [31:0]          sh_rs2_val,
  input  logic [31:0]          ld_inst,
  input  logic [31:0]          ld_pc,
  input  logic [ROB_TAG_W-1:0] ld_tag,
  input  logic                 ld_rs1_rdy,
  input  logic [ROB_TAG_W-1:0] ld_rs1_tag,
  input  logic [31:0]          ld_rs1_val,
  input  logic                 ld_rs2_rdy,
  input  logic [ROB_TAG_W-1:0] ld_rs2_tag,
  input  logic [31:0]          ld_rs2_val,
  output logic                 valid,
  output logic [31:0]          inst,
  output logic [31:0]          pc,
  output logic [ROB_TAG_W-1:0] tag,
  output logic                 rs1_rdy,
  output logic [ROB_TAG_W-1:0] rs1_tag,
  output logic [31:0]          rs1_val,
  output logic                 rs2_rdy,
  output logic [ROB_TAG_W-1:0] rs2_tag,
  output logic [31:0]          rs2_val
);

  logic                 n_valid, n_rs1_rdy, n_rs2_rdy;
  logic [31:0]          n_inst, n_pc, n_rs1_val, n_rs2_val;
  logic [ROB_TAG_W-1:0] n_tag, n_rs1_tag, n_rs2_tag;

  always_comb begin
    n_valid   = valid;
    n_inst    = inst;
    n_pc      = pc;
    n_tag     = tag;
    n_rs1_rdy = rs1_rdy;
    n_rs1_tag = rs1_tag;
    n_rs1_val = rs1_val;
    n_rs2_rdy = rs2_rdy;
    n_rs2_tag = rs2_tag;
    n_rs2_val = rs2_val;
    case (sel)
      SLOT_SHIFT: begin
        n_valid   = sh_valid;
        n_inst    = sh_inst;
        n_pc      = sh_pc;
        n_tag     = sh_tag;
        n_rs1_rdy = sh_rs1_rdy;
        n_rs1_tag = sh_rs1_tag;
        n_rs1_val = sh_rs1_val;
        n_rs2_rdy = sh_rs2_rdy;
        n_rs2_tag = sh_rs2_tag;
        n_rs2_val = sh_rs2_val;
      end
      SLOT_LOAD: begin
        n_valid   = 1'b1;
        n_inst    = ld_inst;
        n_pc      = ld_pc;
        n_tag     = ld_tag;
        n_rs1_rdy = ld_rs1_rdy;
        n_rs1_tag = ld_rs1_tag;
        n_rs1_val = ld_rs1_val;
        n_rs2_rdy = ld_rs2_rdy;
        n_rs2_tag = ld_rs2_tag;
        n_rs2_val = ld_rs2_val;
      end
      SLOT_CLEAR: n_valid = 1'b0;
      default:    n_valid = valid;
    endcase
    // Snoop after the source mux so shifting and freshly dispatched operands also capture.
    if (cdb_valid && !n_rs1_rdy && (n_rs1_tag == cdb_tag)) begin
      n_rs1_rdy = 1'b1;
      n_rs1_val = cdb_value;
    end
    if (cdb_valid && !n_rs2_rdy && (n_rs2_tag == cdb_tag)) begin
      n_rs2_rdy = 1'b1;
      n_rs2_val = cdb_value;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) valid <= 1'b0;
    else         valid <= n_valid;
  end

  always_ff @(posedge clk_i) begin
    inst    <= n_inst;
    pc      <= n_pc;
    tag     <= n_tag;
    rs1_rdy <= n_rs1_rdy;
    rs1_tag <= n_rs1_tag;
    rs1_val <= n_rs1_val;
    rs2_rdy <= n_rs2_rdy;
    rs2_tag <= n_rs2_tag;
    rs2_val <= n_rs2_val;
  end

endmodule

// File: rtl/mul_issue_queue.sv
// Collapsing in-order-priority issue queue for MUL-class ops feeding a 1-cycle multiplier,
// with CDB operand wakeup and a single registered writeback stage.
module mul_issue_queue
  import muldiv_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ROB_TAG_W = ROB_TAG_W_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 dispatch_valid_i,
  output logic                 dispatch_ready_o,
  input  logic [31:0]          dispatch_inst_i,
  input  logic [31:0]          dispatch_pc_i,
  input  logic [ROB_TAG_W-1:0] dispatch_tag_i,
  input  logic                 rs1_ready_i,
  input  logic                 rs2_ready_i,
  input  logic [31:0]          rs1_value_i,
  input  logic [31:0]          rs2_value_i,
  input  logic [ROB_TAG_W-1:0] rs1_tag_i,
  input  logic [ROB_TAG_W-1:0] rs2_tag_i,
  input  logic                 cdb_valid_i,
  input  logic [ROB_TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]          cdb_value_i,
  output logic                 mul_request_o,
  output logic [31:0]          mul_inst_o,
  output logic [31:0]          mul_pc_o,
  output logic [31:0]          mul_rs1_value_o,
  output logic [31:0]          mul_rs2_value_o,
  input  logic [31:0]          mul_value_i,
  output logic                 wb_valid_o,
  output logic [ROB_TAG_W-1:0] wb_tag_o,
  output logic [31:0]          wb_value_o,
  input  logic                 flush_i
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]     ent_valid, ent_rs1_rdy, ent_rs2_rdy;
  logic [31:0]          ent_inst    [DEPTH];
  logic [31:0]          ent_pc      [DEPTH];
  logic [31:0]          ent_rs1_val [DEPTH];
  logic [31:0]          ent_rs2_val [DEPTH];
  logic [ROB_TAG_W-1:0] ent_tag     [DEPTH];
  logic [ROB_TAG_W-1:0] ent_rs1_tag [DEPTH];
  logic [ROB_TAG_W-1:0] ent_rs2_tag [DEPTH];

  logic                 issue_found, issue_valid, dispatch_fire, wb_valid_q;
  logic [IDX_W-1:0]     issue_idx;
  logic [CNT_W-1:0]     occ_cnt, free_idx;
  logic [ROB_TAG_W-1:0] wb_tag_q;

  // Derived only from registered valids, so a full queue stays not-ready even when issuing.
  assign dispatch_ready_o = ~&ent_valid;
  assign dispatch_fire    = dispatch_valid_i & dispatch_ready_o & ~flush_i;

  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    occ_cnt     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_cnt = occ_cnt + CNT_W'(ent_valid[i]);
      if (!issue_found && ent_valid[i] && ent_rs1_rdy[i] && ent_rs2_rdy[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_valid = issue_found & ~flush_i;
  // Valids stay packed from index 0, so the post-collapse occupancy is the free slot.
  assign free_idx    = occ_cnt - CNT_W'(issue_valid);

  assign mul_request_o   = issue_valid;
  assign mul_inst_o      = ent_inst[issue_idx];
  assign mul_pc_o        = ent_pc[issue_idx];
  assign mul_rs1_value_o = ent_rs1_val[issue_idx];
  assign mul_rs2_value_o = ent_rs2_val[issue_idx];

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    slot_sel_e            sel;
    logic                 sh_valid, sh_rs1_rdy, sh_rs2_rdy;
    logic [31:0]          sh_inst, sh_pc, sh_rs1_val, sh_rs2_val;
    logic [ROB_TAG_W-1:0] sh_tag, sh_rs1_tag, sh_rs2_tag;

    if (i < DEPTH - 1) begin : g_shift
      assign sh_valid   = ent_valid[i+1];
      assign sh_inst    = ent_inst[i+1];
      assign sh_pc      = ent_pc[i+1];
      assign sh_tag     = ent_tag[i+1];
      assign sh_rs1_rdy = ent_rs1_rdy[i+1];
      assign sh_rs1_tag = ent_rs1_tag[i+1];
      assign sh_rs1_val = ent_rs1_val[i+1];
      assign sh_rs2_rdy = ent_rs2_rdy[i+1];
      assign sh_rs2_tag = ent_rs2_tag[i+1];
      assign sh_rs2_val = ent_rs2_val[i+1];
    end else begin : g_top
      assign sh_valid   = 1'b0;
      assign sh_inst    = '0;
      assign sh_pc      = '0;
      assign sh_tag     = '0;
      assign sh_rs1_rdy = 1'b0;
      assign sh_rs1_tag = '0;
      assign sh_rs1_val = '0;
      assign sh_rs2_rdy = 1'b0;
      assign sh_rs2_tag = '0;
      assign sh_rs2_val = '0;
    end

    always_comb begin
      sel = SLOT_HOLD;
      if (flush_i)                                           sel = SLOT_CLEAR;
      else if (dispatch_fire && (free_idx == CNT_W'(i)))     sel = SLOT_LOAD;
      else if (issue_valid && (IDX_W'(i) >= issue_idx))      sel = (i == DEPTH - 1) ? SLOT_CLEAR : SLOT_SHIFT;
    end

    mul_rs_entry #(.ROB_TAG_W(ROB_TAG_W)) u_entry (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .sel        (sel),
      .cdb_valid  (cdb_valid_i),
      .cdb_tag    (cdb_tag_i),
      .cdb_value  (cdb_value_i),
      .sh_valid   (sh_valid),
      .sh_inst    (sh_inst),
      .sh_pc      (sh_pc),
      .sh_tag     (sh_tag),
      .sh_rs1_rdy (sh_rs1_rdy),
      .sh_rs1_tag (sh_rs1_tag),
      .sh_rs1_val (sh_rs1_val),
      .sh_rs2_rdy (sh_rs2_rdy),
      .sh_rs2_tag (sh_rs2_tag),
      .sh_rs2_val (sh_rs2_val),
      .ld_inst    (dispatch_inst_i),
      .ld_pc      (dispatch_pc_i),
      .ld_tag     (dispatch_tag_i),
      .ld_rs1_rdy (rs1_ready_i),
      .ld_rs1_tag (rs1_tag_i),
      .ld_rs1_val (rs1_value_i),
      .ld_rs2_rdy (rs2_ready_i),
      .ld_rs2_tag (rs2_tag_i),
      .ld_rs2_val (rs2_value_i),
      .valid      (ent_valid[i]),
      .inst       (ent_inst[i]),
      .pc         (ent_pc[i]),
      .tag        (ent_tag[i]),
      .rs1_rdy    (ent_rs1_rdy[i]),
      .rs1_tag    (ent_rs1_tag[i]),
      .rs1_val    (ent_rs1_val[i]),
      .rs2_rdy    (ent_rs2_rdy[i]),
      .rs2_tag    (ent_rs2_tag[i]),
      .rs2_val    (ent_rs2_val[i])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wb_valid_q <= 1'b0;
    else         wb_valid_q <= issue_valid;
  end

  always_ff @(posedge clk_i) begin
    if (issue_valid) wb_tag_q <= ent_tag[issue_idx];
  end

  assign wb_valid_o = wb_valid_q;
  assign wb_tag_o   = wb_tag_q;
  assign wb_value_o = mul_value_i;

  a_mul_only: assert property (@(posedge clk_i) disable iff (reset_i)
    dispatch_fire |-> is_mul_funct3(dispatch_inst_i));

endmodule

// File: tb/tb_mul_issue_queue.sv
// Directed, table-driven bench for mul_issue_queue: per-cycle stimulus with hand-computed expectations.
module tb_mul_issue_queue;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        dispatch_valid_i, dispatch_ready_o;
  logic [31:0] dispatch_inst_i, dispatch_pc_i;
  logic [4:0]  dispatch_tag_i;
  logic        rs1_ready_i, rs2_ready_i;
  logic [31:0] rs1_value_i, rs2_value_i;
  logic [4:0]  rs1_tag_i, rs2_tag_i;
  logic        cdb_valid_i;
  logic [4:0]  cdb_tag_i;
  logic [31:0] cdb_value_i;
  logic        mul_request_o;
  logic [31:0] mul_inst_o, mul_pc_o, mul_rs1_value_o, mul_rs2_value_o;
  logic [31:0] mul_value_i;
  logic        wb_valid_o;
  logic [4:0]  wb_tag_o;
  logic [31:0] wb_value_o;
  logic        flush_i;

  always #5 clk_i = ~clk_i;

  mul_issue_queue #(.DEPTH(4), .ROB_TAG_W(5)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
    .dispatch_inst_i(dispatch_inst_i), .dispatch_pc_i(dispatch_pc_i), .dispatch_tag_i(dispatch_tag_i),
    .rs1_ready_i(rs1_ready_i), .rs2_ready_i(rs2_ready_i),
    .rs1_value_i(rs1_value_i), .rs2_value_i(rs2_value_i),
    .rs1_tag_i(rs1_tag_i), .rs2_tag_i(rs2_tag_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
    .mul_request_o(mul_request_o), .mul_inst_o(mul_inst_o), .mul_pc_o(mul_pc_o),
    .mul_rs1_value_o(mul_rs1_value_o), .mul_rs2_value_o(mul_rs2_value_o),
    .mul_value_i(mul_value_i), .wb_valid_o(wb_valid_o), .wb_tag_o(wb_tag_o),
    .wb_value_o(wb_value_o), .flush_i(flush_i)
  );

  typedef struct {
    logic dv; logic [4:0] dtag;
    logic r1; logic [31:0] v1; logic [4:0] t1;
    logic r2; logic [31:0] v2; logic [4:0] t2;
    logic cv; logic [4:0] ct; logic [31:0] cval;
    logic fl; logic [31:0] mval;
    logic e_rdy; logic e_req; logic [4:0] e_itag; logic [31:0] e_v1; logic [31:0] e_v2;
    logic e_wb; logic [4:0] e_wtag;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input int unsigned dv, dtag, r1, v1, t1, r2, v2, t2, cv, ct, cval,
                              fl, mval, e_rdy, e_req, e_itag, e_v1, e_v2, e_wb, e_wtag);
    vec_t r;
    r.dv = 1'(dv);   r.dtag = 5'(dtag);
    r.r1 = 1'(r1);   r.v1 = v1;   r.t1 = 5'(t1);
    r.r2 = 1'(r2);   r.v2 = v2;   r.t2 = 5'(t2);
    r.cv = 1'(cv);   r.ct = 5'(ct); r.cval = cval;
    r.fl = 1'(fl);   r.mval = mval;
    r.e_rdy = 1'(e_rdy); r.e_req = 1'(e_req); r.e_itag = 5'(e_itag);
    r.e_v1 = e_v1;   r.e_v2 = e_v2;
    r.e_wb = 1'(e_wb); r.e_wtag = 5'(e_wtag);
    return r;
  endfunction

  // rd carries the tag and funct3 cycles through MUL..MULHU so every issue is distinguishable.
  function automatic logic [31:0] inst_of(input logic [4:0] t);
    return 32'h0220_8033 | {20'b0, t, 7'b0} | {18'b0, t[1:0], 12'b0};
  endfunction

  function automatic logic [31:0] pc_of(input logic [4:0] t);
    return 32'h0000_1000 + {25'b0, t, 2'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dispatch_valid_i = v.dv;
    dispatch_tag_i   = v.dtag;
    dispatch_inst_i  = inst_of(v.dtag);
    dispatch_pc_i    = pc_of(v.dtag);
    rs1_ready_i = v.r1; rs1_value_i = v.v1; rs1_tag_i = v.t1;
    rs2_ready_i = v.r2; rs2_value_i = v.v2; rs2_tag_i = v.t2;
    cdb_valid_i = v.cv; cdb_tag_i = v.ct; cdb_value_i = v.cval;
    flush_i     = v.fl;
    mul_value_i = v.mval;
  endtask

  task automatic apply_check(input vec_t v, input int idx);
    drive(v);
    @(negedge clk_i);
    chk($sformatf("v%0d.ready", idx), 32'(dispatch_ready_o), 32'(v.e_rdy));
    chk($sformatf("v%0d.request", idx), 32'(mul_request_o), 32'(v.e_req));
    if (v.e_req) begin
      chk($sformatf("v%0d.inst", idx), mul_inst_o, inst_of(v.e_itag));
      chk($sformatf("v%0d.pc", idx), mul_pc_o, pc_of(v.e_itag));
      chk($sformatf("v%0d.rs1", idx), mul_rs1_value_o, v.e_v1);
      chk($sformatf("v%0d.rs2", idx), mul_rs2_value_o, v.e_v2);
    end
    chk($sformatf("v%0d.wb_valid", idx), 32'(wb_valid_o), 32'(v.e_wb));
    if (v.e_wb) begin
      chk($sformatf("v%0d.wb_tag", idx), 32'(wb_tag_o), 32'(v.e_wtag));
      chk($sformatf("v%0d.wb_value", idx), wb_value_o, v.mval);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0);

    // Single ready MUL: 7*6 tagged 3
    tbl.push_back(mk(1,3, 1,7,0, 1,6,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 1,1,3,7,6, 0,0));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,42, 1,0,0,0,0, 1,3));
    // rs2 waits on tag 9, woken two cycles later
    tbl.push_back(mk(1,4, 1,5,0, 0,0,9, 0,0,0, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(idle);
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,9,'hFFFF_FFFF, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 1,1,4,5,'hFFFF_FFFF, 0,0));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,'h1234_5678, 1,0,0,0,0, 1,4));
    // CDB matches rs1 of the op being dispatched
    tbl.push_back(mk(1,6, 0,0,11, 1,3,0, 1,11,'h100, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 1,1,6,'h100,3, 0,0));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,'h300, 1,0,0,0,0, 1,6));
    // Fill with four waiting ops, wake the third, collapse and refuse dispatch while full
    tbl.push_back(mk(1,20, 0,0,10, 1,2,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(1,21, 0,0,11, 1,2,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(1,22, 0,0,12, 1,2,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(1,23, 0,0,13, 1,2,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(1,24, 1,9,0, 1,9,0, 1,12,'h50, 0,0, 0,0,0,0,0, 0,0));
    tbl.push_back(mk(1,24, 1,9,0, 1,9,0, 0,0,0, 0,0, 0,1,22,'h50,2, 0,0));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,13,'h60, 0,'h77, 1,0,0,0,0, 1,22));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 1,1,23,'h60,2, 0,0));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,'h88, 1,0,0,0,0, 1,23));
    // Issue entry 20 while dispatching 25, then flush with two entries and a wb in flight
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,10,'hA, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(1,25, 0,0,14, 1,4,0, 1,11,'hB, 0,0, 1,1,20,'hA,2, 0,0));
    tbl.push_back(mk(1,26, 1,1,0, 1,1,0, 0,0,0, 1,'h99, 1,0,0,0,0, 1,20));
    tbl.push_back(mk(0,0, 0,0,0, 0,0,0, 1,14,'hE, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(idle);
    // Three pending ops waiting on tag 30, plus a ready one
    tbl.push_back(mk(1,2, 0,0,30, 1,1,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(1,3, 0,0,30, 1,1,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(1,4, 0,0,30, 1,1,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0));
    tbl.push_back(mk(1,1, 1,3,0, 1,5,0, 0,0,0, 0,0, 1,0,0,0,0, 0,0));

    drive(idle);
    reset_i = 1'b1;
    #12;
    chk("reset.ready", 32'(dispatch_ready_o), 32'd1);
    chk("reset.request", 32'(mul_request_o), 32'd0);
    chk("reset.wb_valid", 32'(wb_valid_o), 32'd0);
    step();
    reset_i = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply_check(tbl[i], i);
      step();
    end

    // Full queue issuing tag 1; reset lands mid-cycle before the issuing edge
    apply_check(mk(0,0, 0,0,0, 0,0,0, 0,0,0, 0,0, 0,1,1,3,5, 0,0), 100);
    reset_i = 1'b1;
    #1;
    chk("midreset.ready", 32'(dispatch_ready_o), 32'd1);
    chk("midreset.request", 32'(mul_request_o), 32'd0);
    chk("midreset.wb_valid", 32'(wb_valid_o), 32'd0);
    @(posedge clk_i);
    #3;
    reset_i = 1'b0;
    apply_check(mk(0,0, 0,0,0, 0,0,0, 1,30,'h33, 0,0, 1,0,0,0,0, 0,0), 101);
    step();
    apply_check(idle, 102);
    step();
    apply_check(idle, 103);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_issue_queue.md
MUL_ISSUE_QUEUE -- requirements
Module: mul_issue_queue

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, number of reservation entries; ROB_TAG_W, default 5, ROB tag width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, using these ports: clk_i  input  1  clock, all state updates on rising edge; reset_i  input  1  asynchronous active-high reset.
REQ-003 SHALL have dispatch ports: dispatch_valid_i  input  1  new MUL-class op; dispatch_ready_o  output  1  free entry exists; dispatch_inst_i  input  32  instruction; dispatch_pc_i  input  32  PC; dispatch_tag_i  input  ROB_TAG_W  destination ROB tag.
REQ-004 SHALL have source operand ports: rs1_ready_i/rs2_ready_i  input  1  value valid; rs1_value_i/rs2_value_i  input  32  value; rs1_tag_i/rs2_tag_i  input  ROB_TAG_W  producer tag when not ready.
REQ-005 SHALL have CDB snoop ports: cdb_valid_i  input  1; cdb_tag_i  input  ROB_TAG_W; cdb_value_i  input  32.
REQ-006 SHALL have issue ports to the multiplier: mul_request_o  output  1; mul_inst_o  output  32; mul_pc_o  output  32; mul_rs1_value_o/mul_rs2_value_o  output  32.
REQ-007 SHALL have result ports: mul_value_i  input  32  multiplier result; wb_valid_o  output  1; wb_tag_o  output  ROB_TAG_W; wb_value_o  output  32; flush_i  input  1  pipeline flush.

Function
REQ-008 SHALL hold entries in a collapsing queue; index 0 is the oldest, and each entry holds valid, inst, pc, tag, and per-operand ready/tag/value.
REQ-009 SHALL drive dispatch_ready_o = 1 when at least one entry is invalid, using state from the previous edge only; there is no combinational path from issue to ready.
REQ-010 SHALL accept a dispatch when dispatch_valid_i && dispatch_ready_o, writing it into the lowest free index after the same-cycle collapse.
REQ-011 SHALL, when cdb_valid_i is high, mark as ready every valid, not-ready operand whose tag equals cdb_tag_i and capture cdb_value_i.
REQ-012 SHALL apply CDB capture to operands dispatched in the same cycle (tag match with rs*_ready_i=0) and to entries shifting in the same cycle.
REQ-013 SHALL issue each cycle the lowest-index valid entry with both operands ready: mul_request_o=1, with inst/pc/values driven combinationally from that entry, and the entry removed at the edge.
REQ-014 SHALL, on removal, shift entries above the issued index down by one; at most one issue per cycle.
REQ-015 SHALL make an entry dispatched with both operands ready eligible to issue no earlier than the following cycle.
REQ-016 SHALL, for a request issued in cycle T, drive wb_valid_o=1 in cycle T+1 with wb_tag_o = the registered tag and wb_value_o = mul_value_i (multiplier latency = 1).
REQ-017 SHALL support back-to-back issue: one writeback per cycle, never stalled; wb has no backpressure.
REQ-018 SHALL accept only funct3[2]=0 (MUL/MULH/MULHSU/MULHU); dispatching funct3[2]=1 is illegal and checked by an assertion.
REQ-019 SHALL, on flush_i, clear all entry valids and the in-flight wb valid at the edge, suppress issue in that cycle, and ignore any dispatch in that cycle.
REQ-020 SHALL, when full, with same-cycle issue and dispatch, still deassert dispatch_ready_o (no bypass of full).

Reset
REQ-021 SHALL, on reset_i assertion, immediately clear all entry valids and the wb valid pipeline register; dispatch_ready_o=1, mul_request_o=0, wb_valid_o=0.
REQ-022 SHALL not reset payload fields (inst, pc, values, tags); outputs SHALL be qualified by the valid signals.
REQ-023 SHALL treat reset mid-operation as aborting in-flight results: no wb_valid_o after release for pre-reset issues.

Structure
REQ-024 SHALL place FUNCT3_* constants, ROB_TAG_W default and the MUL_LATENCY=1 constant in shared package muldiv_pkg.
REQ-025 SHALL use one sub-module, mul_rs_entry: a single slot with CDB capture and shift-in mux, instantiated DEPTH times.

Verification
REQ-026 SHALL cover: dispatch MUL, rs1=7 ready, rs2=6 ready, tag 3 -> mul_request_o cycle +1, wb_valid_o/wb_tag_o=3/wb_value_o=42 cycle +2.
REQ-027 SHALL cover: dispatch with rs2 waiting on tag 9, then CDB tag 9 value 0xFFFFFFFF two cycles later -> issue on the cycle after capture with mul_rs2_value_o=0xFFFFFFFF.
REQ-028 SHALL cover: fill 4 entries, none ready -> dispatch_ready_o=0; broadcast entry 2's tag -> entry 2 issues, entry 3 shifts to index 2, ready=1 next cycle.
REQ-029 SHALL cover: CDB tag equal to the dispatching op's rs1_tag_i in the dispatch cycle -> operand captured, issue next cycle.
REQ-030 SHALL cover: flush_i in the cycle after an issue, with 2 valid entries -> wb_valid_o=0, queue empty, dispatch_ready_o=1.
REQ-031 SHALL cover: reset_i asserted mid-clock with 3 entries pending -> outputs reset without waiting for a clock edge; no writeback after release.
